// File: rtl/product_vector_reducer_if.sv
// Handshake bundle between the dual-lane multiplier, the product reducer and the next stage.
interface product_vector_reducer_if #(
   parameter int N     = 8,
   parameter int PW    = 2 * N,
   parameter int OUT_W = 2 * N + $clog2(N)
);
   logic              in_valid;
   logic              in_ready;
   logic [N*PW-1:0]   prod_ab;
   logic [N*PW-1:0]   prod_cd;
   logic              out_valid;
   logic              out_ready;
   logic [OUT_W-1:0]  dot_ab;
   logic [OUT_W-1:0]  dot_cd;
   logic              sat_ab;
   logic              sat_cd;

   modport master (
      output in_valid, prod_ab, prod_cd, out_ready,
      input  in_ready, out_valid, dot_ab, dot_cd, sat_ab, sat_cd
   );

   modport slave (
      input  in_valid, prod_ab, prod_cd, out_ready,
      output in_ready, out_valid, dot_ab, dot_cd, sat_ab, sat_cd
   );
endinterface

// File: rtl/product_vector_reducer.sv
// Sums N products per lane (ab, cd) one element per clock and hands both dot products downstream.
// Optional saturating accumulation is enabled by defining PRODUCT_REDUCER_SAT_EN.
module product_vector_reducer #(
   parameter int N     = 8,
   parameter int PW    = 2 * N,
   parameter int OUT_W = 2 * N + $clog2(N)
) (
   input  logic                       clk,
   input  logic                       rst,
   product_vector_reducer_if.slave    bus,
   output logic                       busy
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     idx;
   logic [PW-1:0]     ab_q [N];
   logic [PW-1:0]     cd_q [N];
   logic [OUT_W-1:0]  acc_ab, acc_cd;
   logic [OUT_W-1:0]  nxt_ab, nxt_cd;
   logic              in_ready, out_valid;
   logic              accept, last;

   assign accept = bus.in_valid && in_ready;
   assign last   = (idx == IW'(N - 1));

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) state_d = ACCUM;
         end
         ACCUM: begin
            if (last) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx     <= '0;
         acc_ab  <= '0;
         acc_cd  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && accept) begin
            for (int unsigned i = 0; i < N; i++) begin
               ab_q[i] <= bus.prod_ab[i*PW +: PW];
               cd_q[i] <= bus.prod_cd[i*PW +: PW];
            end
            acc_ab <= '0;
            acc_cd <= '0;
            idx    <= '0;
         end else if (state_q == ACCUM) begin
            acc_ab <= nxt_ab;
            acc_cd <= nxt_cd;
            idx    <= idx + 1'b1;
         end
      end
   end

`ifdef PRODUCT_REDUCER_SAT_EN
   logic [OUT_W:0] sum_ab, sum_cd;
   logic           sat_ab_q, sat_cd_q;
   logic           nxt_sat_ab, nxt_sat_cd;

   // Once a lane has clamped it stays pinned at full scale for the rest of the vector.
   always_comb begin
      sum_ab     = {1'b0, acc_ab} + (OUT_W+1)'(ab_q[idx]);
      sum_cd     = {1'b0, acc_cd} + (OUT_W+1)'(cd_q[idx]);
      nxt_sat_ab = sum_ab[OUT_W] || sat_ab_q;
      nxt_sat_cd = sum_cd[OUT_W] || sat_cd_q;
      nxt_ab     = nxt_sat_ab ? '1 : sum_ab[OUT_W-1:0];
      nxt_cd     = nxt_sat_cd ? '1 : sum_cd[OUT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst || (state_q == IDLE && accept)) begin
         sat_ab_q <= 1'b0;
         sat_cd_q <= 1'b0;
      end else if (state_q == ACCUM) begin
         sat_ab_q <= nxt_sat_ab;
         sat_cd_q <= nxt_sat_cd;
      end
   end

   assign bus.sat_ab = sat_ab_q;
   assign bus.sat_cd = sat_cd_q;
`else
   always_comb begin
      nxt_ab = acc_ab + OUT_W'(ab_q[idx]);
      nxt_cd = acc_cd + OUT_W'(cd_q[idx]);
   end

   assign bus.sat_ab = 1'b0;
   assign bus.sat_cd = 1'b0;
`endif

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.dot_ab    = acc_ab;
   assign bus.dot_cd    = acc_cd;
   assign busy          = (state_q != IDLE);
endmodule

// File: doc/product_vector_reducer.md
Name: product_vector_reducer

Overview:
- Downstream stage of the dual-lane elementwise multiplier.
- Captures one vector of N products per lane (ab and cd) through a valid/ready handshake.
- Sequentially sums the N elements of each lane, one element per clock, giving two dot-product results.
- Presents both results on a valid/ready output handshake to the next stage.

Parameters:
- N, 8: elements per vector; also operand width of the upstream multiplier.
- PW, 2*N: width of one product element.
- OUT_W, 2*N+$clog2(N): accumulator and result width. The default cannot overflow.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  product vectors on prod_ab/prod_cd are valid.
- in_ready  output  1  block can accept a vector pair.
- prod_ab  input  N*PW  lane ab products, unsigned; element i at bits [i*PW +: PW].
- prod_cd  input  N*PW  lane cd products, same packing as prod_ab.
- out_valid  output  1  dot_ab/dot_cd hold a completed result.
- out_ready  input  1  downstream accepts the result.
- dot_ab  output  OUT_W  sum of the lane ab elements.
- dot_cd  output  OUT_W  sum of the lane cd elements.
- sat_ab  output  1  lane ab result was clamped (see Optional Feature).
- sat_cd  output  1  lane cd result was clamped (see Optional Feature).
- busy  output  1  state is not IDLE.

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high on rst, sampled at the rising edge of clk.
  - rst has priority over every other event, including mid-ACCUM and DONE; any in-flight vector is discarded.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, dot_ab=0, dot_cd=0, sat_ab=0, sat_cd=0, idx=0.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register prod_ab and prod_cd, clear both accumulators and sat flags, set idx=0, go to ACCUM.
- ACCUM:
  - in_ready=0.
  - Each edge adds element idx of each captured lane to its accumulator, then idx++.
  - The edge that adds idx=N-1 moves to DONE.
  - Exactly N edges are spent in ACCUM.
- DONE:
  - out_valid=1; dot_* and sat_* are stable.
  - On out_valid&&out_ready, go to IDLE; out_valid drops on that same edge.
  - Holding out_ready low holds DONE indefinitely; no new input is accepted.
- Timing:
  - Latency: out_valid rises N edges after the accepting edge.
  - Minimum initiation interval: N+2 cycles (accept, N accumulate edges, output handshake).
  - No overlap between result drain and the next accept: in_ready is 1 only in IDLE.
- Inputs:
  - prod_* are sampled only on the accepting edge.
  - Changes to prod_* during ACCUM or DONE have no effect.
  - in_valid outside IDLE is ignored and is not counted.
- Arithmetic:
  - Unsigned; each element is zero-extended to OUT_W.
  - Without the optional feature, overflow wraps modulo 2^OUT_W.
- Outputs:
  - dot_* show the accumulator at all times; they are only meaningful while out_valid=1.
  - After a drain, dot_* keep their last value until the next accept clears them.
- N=1: ACCUM lasts one edge.

Optional Feature:
- Macro: PRODUCT_REDUCER_SAT_EN.
- When defined:
  - Each add computes OUT_W+1 bits.
  - If the carry-out is set, the accumulator is clamped to 2^OUT_W-1 and the lane's sat_* is set.
  - sat_* is sticky for the vector, cleared on the next accept, and stays clamped through the remaining adds.
- When undefined:
  - Sums wrap modulo 2^OUT_W.
  - sat_ab and sat_cd are tied to 0.
  - No extra logic is generated.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> in_ready=1, out_valid=0, busy=0, dot_*=0.
- Basic reduction, N=8:
  - Stimulus: ab elements 1..8; cd elements all 3; accept at cycle 0; out_ready=1.
  - Response: out_valid at edge 8, dot_ab=36, dot_cd=24; IDLE at edge 9.
- Backpressure:
  - Stimulus: same vectors, out_ready=0 for 5 cycles after out_valid; in_valid held high with new data throughout.
  - Response: dot_* stay 36/24; in_ready=0; new data not taken until IDLE returns.
- Mid-ACCUM reset:
  - Stimulus: assert rst at edge 4 after accept.
  - Response: next cycle IDLE, dot_*=0, out_valid never pulses for that vector.
- Full-scale values:
  - Stimulus: all elements 65025 (255*255), default OUT_W=19.
  - Response: dot_ab=dot_cd=520200, sat_*=0.
- Overflow with OUT_W=16, all elements 65025:
  - Without PRODUCT_REDUCER_SAT_EN: dot_*=61448, sat_*=0.
  - With PRODUCT_REDUCER_SAT_EN: dot_*=65535, sat_*=1.
